// File: rtl/register_file_pkg.sv
// Shared widths for the architectural register file and its operand resolvers.
package register_file_pkg;
    localparam int ROB_BITS_DEF = 3;
    localparam int REG_NUM      = 32;
    localparam int REG_BITS     = 5;
    localparam int XLEN         = 32;
endpackage

// File: rtl/register_file_operand_resolve.sv
// Resolves one decoder source operand to a value or an outstanding ROB tag.
module register_file_operand_resolve
    import register_file_pkg::*;
#(
    parameter int ROB_BITS = ROB_BITS_DEF
) (
    input  logic [REG_BITS-1:0] i_rs,
    input  logic                i_busy,
    input  logic [ROB_BITS-1:0] i_tag,
    input  logic [XLEN-1:0]     i_val,
    input  logic                i_commit_valid,
    input  logic [REG_BITS-1:0] i_commit_reg,
    input  logic [XLEN-1:0]     i_commit_val,
    input  logic [ROB_BITS-1:0] i_commit_rob_id,
    input  logic                i_rob_ready,
    input  logic [XLEN-1:0]     i_rob_value,
    output logic [ROB_BITS-1:0] o_query_id,
    output logic                o_ready,
    output logic [XLEN-1:0]     o_value,
    output logic [ROB_BITS-1:0] o_dep
);
    logic w_commit_hit;

    assign w_commit_hit = i_commit_valid && (i_commit_reg == i_rs) && i_busy
                          && (i_tag == i_commit_rob_id);

    always_comb begin
        o_query_id = i_tag;
        o_ready    = 1'b1;
        o_value    = '0;
        o_dep      = '0;
        if (i_rs == '0) begin
            o_value = '0;
        end else if (w_commit_hit) begin
            o_value = i_commit_val;
        end else if (i_busy) begin
            // Producer still in flight: the ROB forwarding port may already hold it.
            o_ready = i_rob_ready;
            o_value = i_rob_ready ? i_rob_value : '0;
            o_dep   = i_tag;
        end else begin
            o_value = i_val;
        end
    end
endmodule

// File: rtl/register_file.sv
// Architectural register file with rename tags, committed by the ROB and read by decode.
module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_BITS = ROB_BITS_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_rdy,
    input  logic                i_clear,
    input  logic                i_commit_valid,
    input  logic [REG_BITS-1:0] i_commit_reg,
    input  logic [XLEN-1:0]     i_commit_val,
    input  logic [ROB_BITS-1:0] i_commit_rob_id,
    input  logic                i_dep_valid,
    input  logic [REG_BITS-1:0] i_dep_reg,
    input  logic [ROB_BITS-1:0] i_dep_rob_id,
    input  logic [REG_BITS-1:0] i_rs1,
    input  logic [REG_BITS-1:0] i_rs2,
    output logic [ROB_BITS-1:0] o_rob_query_id1,
    output logic [ROB_BITS-1:0] o_rob_query_id2,
    input  logic                i_rob_value1_ready,
    input  logic [XLEN-1:0]     i_rob_value1,
    input  logic                i_rob_value2_ready,
    input  logic [XLEN-1:0]     i_rob_value2,
    output logic                o_rs1_ready,
    output logic [XLEN-1:0]     o_rs1_value,
    output logic [ROB_BITS-1:0] o_rs1_dep,
    output logic                o_rs2_ready,
    output logic [XLEN-1:0]     o_rs2_value,
    output logic [ROB_BITS-1:0] o_rs2_dep
);
    logic [XLEN-1:0]     r_val  [REG_NUM];
    logic                r_busy [REG_NUM];
    logic [ROB_BITS-1:0] r_tag  [REG_NUM];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_val[i]  <= '0;
                r_busy[i] <= 1'b0;
                r_tag[i]  <= '0;
            end
        end else if (i_rdy) begin
            // x0 is skipped so it stays zero and never busy.
            for (int i = 1; i < REG_NUM; i++) begin
                if (i_commit_valid && i_commit_reg == REG_BITS'(i)) begin
                    r_val[i] <= i_commit_val;
                end
                if (i_clear) begin
                    r_busy[i] <= 1'b0;
                end else if (i_dep_valid && i_dep_reg == REG_BITS'(i)) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= i_dep_rob_id;
                end else if (i_commit_valid && i_commit_reg == REG_BITS'(i)
                             && r_busy[i] && r_tag[i] == i_commit_rob_id) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    register_file_operand_resolve #(.ROB_BITS(ROB_BITS)) u_resolve1 (
        .i_rs            (i_rs1),
        .i_busy          (r_busy[i_rs1]),
        .i_tag           (r_tag[i_rs1]),
        .i_val           (r_val[i_rs1]),
        .i_commit_valid  (i_commit_valid),
        .i_commit_reg    (i_commit_reg),
        .i_commit_val    (i_commit_val),
        .i_commit_rob_id (i_commit_rob_id),
        .i_rob_ready     (i_rob_value1_ready),
        .i_rob_value     (i_rob_value1),
        .o_query_id      (o_rob_query_id1),
        .o_ready         (o_rs1_ready),
        .o_value         (o_rs1_value),
        .o_dep           (o_rs1_dep)
    );

    register_file_operand_resolve #(.ROB_BITS(ROB_BITS)) u_resolve2 (
        .i_rs            (i_rs2),
        .i_busy          (r_busy[i_rs2]),
        .i_tag           (r_tag[i_rs2]),
        .i_val           (r_val[i_rs2]),
        .i_commit_valid  (i_commit_valid),
        .i_commit_reg    (i_commit_reg),
        .i_commit_val    (i_commit_val),
        .i_commit_rob_id (i_commit_rob_id),
        .i_rob_ready     (i_rob_value2_ready),
        .i_rob_value     (i_rob_value2),
        .o_query_id      (o_rob_query_id2),
        .o_ready         (o_rs2_ready),
        .o_value         (o_rs2_value),
        .o_dep           (o_rs2_dep)
    );
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: rename, commit, bypass, flush, stall.
module tb_register_file;
    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        commit_valid;
    logic [4:0]  commit_reg;
    logic [31:0] commit_val;
    logic [2:0]  commit_rob_id;
    logic        dep_valid;
    logic [4:0]  dep_reg;
    logic [2:0]  dep_rob_id;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  rob_query_id1;
    logic [2:0]  rob_query_id2;
    logic        rob_value1_ready;
    logic [31:0] rob_value1;
    logic        rob_value2_ready;
    logic [31:0] rob_value2;
    logic        rs1_ready;
    logic [31:0] rs1_value;
    logic [2:0]  rs1_dep;
    logic        rs2_ready;
    logic [31:0] rs2_value;
    logic [2:0]  rs2_dep;

    int errors = 0;
    int checks = 0;

    register_file #(.ROB_BITS(3)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_rdy              (rdy),
        .i_clear            (clear),
        .i_commit_valid     (commit_valid),
        .i_commit_reg       (commit_reg),
        .i_commit_val       (commit_val),
        .i_commit_rob_id    (commit_rob_id),
        .i_dep_valid        (dep_valid),
        .i_dep_reg          (dep_reg),
        .i_dep_rob_id       (dep_rob_id),
        .i_rs1              (rs1),
        .i_rs2              (rs2),
        .o_rob_query_id1    (rob_query_id1),
        .o_rob_query_id2    (rob_query_id2),
        .i_rob_value1_ready (rob_value1_ready),
        .i_rob_value1       (rob_value1),
        .i_rob_value2_ready (rob_value2_ready),
        .i_rob_value2       (rob_value2),
        .o_rs1_ready        (rs1_ready),
        .o_rs1_value        (rs1_value),
        .o_rs1_dep          (rs1_dep),
        .o_rs2_ready        (rs2_ready),
        .o_rs2_value        (rs2_value),
        .o_rs2_dep          (rs2_dep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rdy = 1'b1; clear = 1'b0;
        commit_valid = 1'b0; commit_reg = '0; commit_val = '0; commit_rob_id = '0;
        dep_valid = 1'b0; dep_reg = '0; dep_rob_id = '0;
        rob_value1_ready = 1'b0; rob_value1 = '0;
        rob_value2_ready = 1'b0; rob_value2 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_rename(input logic [4:0] r, input logic [2:0] id);
        dep_valid = 1'b1; dep_reg = r; dep_rob_id = id;
        step();
    endtask

    task automatic test_reset();
        // Traffic in flight when reset hits: x5 written and renamed.
        commit_valid = 1'b1; commit_reg = 5'd5; commit_val = 32'h99; commit_rob_id = 3'd0;
        dep_valid = 1'b1; dep_reg = 5'd5; dep_rob_id = 3'd2;
        step();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        rs1 = 5'd5; rs2 = 5'd0;
        #1;
        checks++;
        if (rs1_ready !== 1'b1 || rs1_value !== 32'h0) begin
            errors++;
            $display("FAIL reset_rs1: got ready=%b value=%h, want ready=1 value=0", rs1_ready, rs1_value);
        end
        checks++;
        if (rs2_ready !== 1'b1 || rs2_value !== 32'h0 || rs2_dep !== 3'd0) begin
            errors++;
            $display("FAIL reset_rs2: got ready=%b value=%h dep=%0d, want 1/0/0", rs2_ready, rs2_value, rs2_dep);
        end
        $display("reset: rs1 ready=%b value=%h rs2 ready=%b value=%h", rs1_ready, rs1_value, rs2_ready, rs2_value);
        @(negedge clk);
    endtask

    task automatic test_rename_forward();
        do_rename(5'd5, 3'd3);
        rs1 = 5'd5; rob_value1_ready = 1'b0;
        #1;
        checks++;
        if (rs1_ready !== 1'b0 || rs1_dep !== 3'd3 || rob_query_id1 !== 3'd3 || rs1_value !== 32'h0) begin
            errors++;
            $display("FAIL rename_wait: got ready=%b dep=%0d qid=%0d value=%h, want 0/3/3/0",
                     rs1_ready, rs1_dep, rob_query_id1, rs1_value);
        end
        rob_value1_ready = 1'b1; rob_value1 = 32'h1234;
        #1;
        checks++;
        if (rs1_ready !== 1'b1 || rs1_value !== 32'h1234) begin
            errors++;
            $display("FAIL rob_forward: got ready=%b value=%h, want 1/1234", rs1_ready, rs1_value);
        end
        $display("rename_forward: x5 tag=%0d forwarded value=%h", rob_query_id1, rs1_value);
        idle();
    endtask

    task automatic test_commit_bypass();
        rs1 = 5'd0; rs2 = 5'd5;
        commit_valid = 1'b1; commit_reg = 5'd5; commit_val = 32'hAB; commit_rob_id = 3'd3;
        #1;
        checks++;
        if (rs2_ready !== 1'b1 || rs2_value !== 32'hAB) begin
            errors++;
            $display("FAIL commit_bypass: got ready=%b value=%h, want 1/ab", rs2_ready, rs2_value);
        end
        step();
        checks++;
        if (rs2_ready !== 1'b1 || rs2_value !== 32'hAB || rs2_dep !== 3'd0) begin
            errors++;
            $display("FAIL commit_retired: got ready=%b value=%h dep=%0d, want 1/ab/0", rs2_ready, rs2_value, rs2_dep);
        end
        $display("commit_bypass: x5 value=%h ready=%b", rs2_value, rs2_ready);
    endtask

    task automatic test_stale_commit();
        do_rename(5'd5, 3'd4);
        rs1 = 5'd5;
        commit_valid = 1'b1; commit_reg = 5'd5; commit_val = 32'd7; commit_rob_id = 3'd3;
        #1;
        checks++;
        if (rs1_ready !== 1'b0 || rs1_dep !== 3'd4) begin
            errors++;
            $display("FAIL stale_no_bypass: got ready=%b dep=%0d, want 0/4", rs1_ready, rs1_dep);
        end
        step();
        checks++;
        if (rs1_ready !== 1'b0 || rs1_dep !== 3'd4) begin
            errors++;
            $display("FAIL stale_keeps_busy: got ready=%b dep=%0d, want 0/4", rs1_ready, rs1_dep);
        end
        do_rename(5'd6, 3'd1);
        rs2 = 5'd6;
        dep_valid = 1'b1; dep_reg = 5'd6; dep_rob_id = 3'd2;
        commit_valid = 1'b1; commit_reg = 5'd6; commit_val = 32'h66; commit_rob_id = 3'd1;
        #1;
        checks++;
        if (rs2_ready !== 1'b1 || rs2_value !== 32'h66) begin
            errors++;
            $display("FAIL rename_commit_bypass: got ready=%b value=%h, want 1/66", rs2_ready, rs2_value);
        end
        step();
        checks++;
        if (rs2_ready !== 1'b0 || rs2_dep !== 3'd2 || rob_query_id2 !== 3'd2) begin
            errors++;
            $display("FAIL rename_wins: got ready=%b dep=%0d qid=%0d, want 0/2/2", rs2_ready, rs2_dep, rob_query_id2);
        end
        // Flushing exposes the committed values that sat behind the busy tags.
        clear = 1'b1;
        step();
        checks++;
        if (rs1_ready !== 1'b1 || rs1_value !== 32'd7) begin
            errors++;
            $display("FAIL stale_value_written: got ready=%b value=%h, want 1/7", rs1_ready, rs1_value);
        end
        checks++;
        if (rs2_ready !== 1'b1 || rs2_value !== 32'h66) begin
            errors++;
            $display("FAIL rename_commit_value: got ready=%b value=%h, want 1/66", rs2_ready, rs2_value);
        end
        $display("stale_commit: x5=%h x6=%h", rs1_value, rs2_value);
    endtask

    task automatic test_clear();
        do_rename(5'd7, 3'd5);
        clear = 1'b1;
        dep_valid = 1'b1; dep_reg = 5'd8; dep_rob_id = 3'd6;
        commit_valid = 1'b1; commit_reg = 5'd9; commit_val = 32'h55; commit_rob_id = 3'd0;
        step();
        rs1 = 5'd7; rs2 = 5'd8;
        #1;
        checks++;
        if (rs1_ready !== 1'b1 || rs1_value !== 32'h0) begin
            errors++;
            $display("FAIL clear_x7: got ready=%b value=%h, want 1/0", rs1_ready, rs1_value);
        end
        checks++;
        if (rs2_ready !== 1'b1 || rs2_value !== 32'h0) begin
            errors++;
            $display("FAIL clear_drops_rename: got ready=%b value=%h, want 1/0", rs2_ready, rs2_value);
        end
        rs1 = 5'd9;
        #1;
        checks++;
        if (rs1_ready !== 1'b1 || rs1_value !== 32'h55) begin
            errors++;
            $display("FAIL clear_commit: got ready=%b value=%h, want 1/55", rs1_ready, rs1_value);
        end
        commit_valid = 1'b1; commit_reg = 5'd0; commit_val = 32'hFF; commit_rob_id = 3'd0;
        dep_valid = 1'b1; dep_reg = 5'd0; dep_rob_id = 3'd7;
        step();
        rs1 = 5'd0;
        #1;
        checks++;
        if (rs1_ready !== 1'b1 || rs1_value !== 32'h0 || rs1_dep !== 3'd0) begin
            errors++;
            $display("FAIL x0_hardwired: got ready=%b value=%h dep=%0d, want 1/0/0", rs1_ready, rs1_value, rs1_dep);
        end
        $display("clear: x9=55 checked, x0 value=%h", rs1_value);
    endtask

    task automatic test_rdy();
        do_rename(5'd12, 3'd5);
        rdy = 1'b0;
        commit_valid = 1'b1; commit_reg = 5'd10; commit_val = 32'd9; commit_rob_id = 3'd0;
        dep_valid = 1'b1; dep_reg = 5'd11; dep_rob_id = 3'd1;
        @(posedge clk);
        #1;
        rdy = 1'b0; clear = 1'b1;
        commit_valid = 1'b0; dep_valid = 1'b0;
        @(posedge clk);
        #1;
        rs1 = 5'd10; rs2 = 5'd11;
        #1;
        checks++;
        if (rs1_ready !== 1'b1 || rs1_value !== 32'h0) begin
            errors++;
            $display("FAIL stall_commit: got ready=%b value=%h, want 1/0", rs1_ready, rs1_value);
        end
        checks++;
        if (rs2_ready !== 1'b1 || rs2_value !== 32'h0) begin
            errors++;
            $display("FAIL stall_rename: got ready=%b value=%h, want 1/0", rs2_ready, rs2_value);
        end
        rs1 = 5'd12; rob_value1_ready = 1'b1; rob_value1 = 32'hBEEF;
        #1;
        checks++;
        if (rs1_ready !== 1'b1 || rs1_value !== 32'hBEEF || rob_query_id1 !== 3'd5) begin
            errors++;
            $display("FAIL stall_read_live: got ready=%b value=%h qid=%0d, want 1/beef/5",
                     rs1_ready, rs1_value, rob_query_id1);
        end
        rob_value1_ready = 1'b0;
        #1;
        checks++;
        if (rs1_ready !== 1'b0 || rs1_dep !== 3'd5) begin
            errors++;
            $display("FAIL stall_clear_ignored: got ready=%b dep=%0d, want 0/5", rs1_ready, rs1_dep);
        end
        $display("rdy_stall: x12 dep=%0d ready=%b", rs1_dep, rs1_ready);
        idle();
    endtask

    initial begin
        rst = 1'b0; rs1 = '0; rs2 = '0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_rename_forward();
        test_commit_bypass();
        test_stale_commit();
        test_clear();
        test_rdy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
